jogador_automatico: RTL and testbench
=====================================

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  T_APERTO 5: clock cycles a button is held.
  T_SOLTO 5: clock cycles of release between presses.
  T_JOGAR 5: clock cycles the jogar pulse is held.
  T_SILENCIO 20: cycles with leds==0 that end an observation.
  N_MAX 16: sequence memory depth.
REQ-002 Ports, one per line (name, direction, width, meaning):
  clock  in  1  single system clock, all logic on rising edge.
  reset  in  1  synchronous, active-high.
  iniciar  in  1  one-cycle request to start an automatic game.
  leds  in  4  game LED outputs, one-hot while an item is displayed.
  pronto  in  1  game finished.
  ganhou  in  1  game won.
  perdeu  in  1  game lost.
  erro_habilita  in  1  enable deliberate wrong press.
  erro_rodada  in  4  round index (0-based) whose last press is corrupted.
  jogar  out  1  start pulse to the game.
  botoes  out  4  button presses to the game.
  ocupado  out  1  high in every state except OCIOSO and FIM.
  fim  out  1  high in FIM.
  resultado  out  2  00 none, 01 ganhou, 10 perdeu, latched on pronto.
  db_invalido  out  1  sticky: non-one-hot leds seen or memory overflow.
  db_rodada  out  4  current round counter.
  db_estado  out  4  state code.

Function
REQ-003 States and db_estado codes: OCIOSO 0, PULSO_JOGAR 1, OBSERVA 2, APERTA 3, SOLTA 4, FIM 15.
REQ-004 OCIOSO: when iniciar=1, clear the round counter, item count, result and db_invalido, then go to PULSO_JOGAR.
REQ-005 PULSO_JOGAR: drive jogar=1 for exactly T_JOGAR cycles, then go to OBSERVA.
REQ-006 OBSERVA: a capture event is leds!=0 in the current cycle with registered leds==0 in the previous cycle.
REQ-007 On a capture event with one-hot leds and n_obs<N_MAX, store mem[n_obs]=leds and increment n_obs.
REQ-008 On a capture event with non-one-hot leds, store nothing and set db_invalido.
REQ-009 On a capture event when n_obs==N_MAX, store nothing and set db_invalido.
REQ-010 A silence counter clears whenever leds!=0 and otherwise increments, saturating at T_SILENCIO.
REQ-011 When the silence counter equals T_SILENCIO and n_obs>0, set idx=0 and go to APERTA.
REQ-012 When the silence counter equals T_SILENCIO and n_obs==0, stay in OBSERVA.
REQ-013 APERTA: drive botoes=mem[idx] for exactly T_APERTO cycles, then go to SOLTA.
REQ-014 Corruption: when erro_habilita=1, db_rodada==erro_rodada and idx==n_obs-1, APERTA drives mem[idx] rotated left by one instead (0001 becomes 0010, 1000 becomes 0001).
REQ-015 SOLTA: drive botoes=0 for exactly T_SOLTO cycles.
REQ-016 At the end of SOLTA with idx<n_obs-1, increment idx and go to APERTA.
REQ-017 At the end of SOLTA with idx==n_obs-1, clear n_obs and the silence counter, increment db_rodada (wrap 15 to 0) and go to OBSERVA.
REQ-018 From any state other than OCIOSO and FIM, pronto=1 latches resultado ({perdeu,ganhou}), forces botoes=0 and jogar=0, and goes to FIM on the next cycle; pronto has priority over every other transition.
REQ-019 FIM: hold resultado; iniciar=1 behaves as in OCIOSO (restart).
REQ-020 botoes is 0 in every state except APERTA; jogar is 0 in every state except PULSO_JOGAR.
REQ-021 All outputs are registered, with no combinational path from inputs to outputs.
REQ-022 Counter widths: each counter is sized to its parameter maximum; n_obs and idx are 5 bits.

Reset
REQ-023 reset=1 on a rising edge SHALL force OCIOSO.
REQ-024 reset SHALL set jogar=0, botoes=0, ocupado=0, fim=0, resultado=00, db_invalido=0, db_rodada=0, n_obs=0, idx=0 and all timers to 0.
REQ-025 reset SHALL override iniciar and pronto in the same cycle and abort any press in progress.
REQ-026 Memory contents are not cleared by reset and are never read before being written.

Structure
REQ-027 Package jogador_pkg SHALL hold the state encoding constants and the resultado codes.
REQ-028 Sub-module jogador_memoria SHALL be a 16x4 synchronous-write, asynchronous-read register file.
REQ-029 The FSM and the timers SHALL live in jogador_automatico.

Verification
REQ-030 Reset mid-APERTA (pressing 0100) -> next cycle botoes=0, db_estado=0, db_rodada=0.
REQ-031 iniciar pulse -> jogar=1 for exactly 5 cycles, then db_estado=2.
REQ-032 leds shows 0001 for 5 cycles, then 0 for 20 cycles -> botoes=0001 for exactly 5 cycles, 0 for 5 cycles, db_rodada=1.
REQ-033 Round 2 leds sequence 0001, 0010, 0100 -> botoes replays 0001, 0010, 0100 with 5/5 timing.
REQ-034 erro_habilita=1, erro_rodada=3, round 3 sequence 0001, 0010, 0100, 0100 -> last press is 1000; game asserts pronto with perdeu -> resultado=10, fim=1.
REQ-035 leds=0011 once, then 17 one-hot items in one observation -> db_invalido=1 and exactly 16 presses replayed.

Source files
------------

// File: rtl/jogador_pkg.sv
// Shared encodings for the automatic game player: FSM state codes, result codes
// and small combinational helpers on 4-bit LED/button vectors.
package jogador_pkg;

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    PULSO_JOGAR = 4'd1,
    OBSERVA     = 4'd2,
    APERTA      = 4'd3,
    SOLTA       = 4'd4,
    FIM         = 4'd15
  } estado_t;

  localparam logic [1:0] RES_NENHUM = 2'b00;
  localparam logic [1:0] RES_GANHOU = 2'b01;
  localparam logic [1:0] RES_PERDEU = 2'b10;

  localparam int MEM_PROF = 16;
  localparam int MEM_AW   = 4;

  function automatic logic um_quente(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] gira_esq(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/jogador_memoria.sv
// 16x4 register file holding the observed LED sequence of the current round:
// synchronous write, asynchronous read.
module jogador_memoria
  import jogador_pkg::*;
(
  input  logic              clock,
  input  logic              escreve,
  input  logic [MEM_AW-1:0] end_escrita,
  input  logic [3:0]        dado_escrita,
  input  logic [MEM_AW-1:0] end_leitura,
  output logic [3:0]        dado_leitura
);

  logic [3:0] mem_r [MEM_PROF];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (escreve) begin
      mem_r[end_escrita] <= dado_escrita;
    end
  end

  assign dado_leitura = mem_r[end_leitura];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: starts a game, watches the LED sequence of each round and
// replays it on the buttons, optionally corrupting the last press of one round.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int T_APERTO   = 5,
  parameter int T_SOLTO    = 5,
  parameter int T_JOGAR    = 5,
  parameter int T_SILENCIO = 20,
  parameter int N_MAX      = 16
)(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] leds,
  input  logic       pronto,
  input  logic       ganhou,
  input  logic       perdeu,
  input  logic       erro_habilita,
  input  logic [3:0] erro_rodada,
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       fim,
  output logic [1:0] resultado,
  output logic       db_invalido,
  output logic [3:0] db_rodada,
  output logic [3:0] db_estado
);

  localparam int T_MAIOR_AS = (T_APERTO > T_SOLTO) ? T_APERTO : T_SOLTO;
  localparam int T_MAIOR    = (T_MAIOR_AS > T_JOGAR) ? T_MAIOR_AS : T_JOGAR;
  localparam int TW         = $clog2(T_MAIOR + 1);
  localparam int SW         = $clog2(T_SILENCIO + 1);

  localparam logic [TW-1:0] FIM_JOGAR  = TW'(T_JOGAR - 1);
  localparam logic [TW-1:0] FIM_APERTO = TW'(T_APERTO - 1);
  localparam logic [TW-1:0] FIM_SOLTO  = TW'(T_SOLTO - 1);
  localparam logic [SW-1:0] SIL_MAX    = SW'(T_SILENCIO);
  localparam logic [4:0]    OBS_MAX    = 5'(N_MAX);

  estado_t       estado_r, estado_caso_s, estado_prox_s;
  logic [TW-1:0] timer_r, timer_prox_s;
  logic [SW-1:0] silencio_r, silencio_prox_s;
  logic [4:0]    n_obs_r, n_obs_prox_s;
  logic [4:0]    idx_r, idx_prox_s;
  logic [3:0]    rodada_r, rodada_prox_s;
  logic [1:0]    resultado_r, resultado_caso_s, resultado_prox_s;
  logic          invalido_r, invalido_prox_s;
  logic [3:0]    leds_ant_r;
  logic          jogar_r, ocupado_r, fim_r;
  logic [3:0]    botoes_r;

  logic          captura_s, grava_s, ultimo_s;
  logic [3:0]    mem_dado_s, botao_s;

  // A capture is the first cycle of a non-zero LED pattern.
  assign captura_s = (leds != 4'd0) && (leds_ant_r == 4'd0);

  jogador_memoria u_memoria (
    .clock        (clock),
    .escreve      (grava_s),
    .end_escrita  (n_obs_r[3:0]),
    .dado_escrita (leds),
    .end_leitura  (idx_prox_s[3:0]),
    .dado_leitura (mem_dado_s)
  );

  // Next-state, counter and sequence-memory control.
  always_comb begin
    estado_caso_s    = estado_r;
    timer_prox_s     = timer_r;
    silencio_prox_s  = silencio_r;
    n_obs_prox_s     = n_obs_r;
    idx_prox_s       = idx_r;
    rodada_prox_s    = rodada_r;
    resultado_caso_s = resultado_r;
    invalido_prox_s  = invalido_r;
    grava_s          = 1'b0;
    case (estado_r)
      OCIOSO, FIM: begin
        if (iniciar) begin
          estado_caso_s    = PULSO_JOGAR;
          timer_prox_s     = {TW{1'b0}};
          silencio_prox_s  = {SW{1'b0}};
          n_obs_prox_s     = 5'd0;
          idx_prox_s       = 5'd0;
          rodada_prox_s    = 4'd0;
          resultado_caso_s = RES_NENHUM;
          invalido_prox_s  = 1'b0;
        end else begin
          estado_caso_s = estado_r;
        end
      end
      PULSO_JOGAR: begin
        if (timer_r == FIM_JOGAR) begin
          estado_caso_s = OBSERVA;
          timer_prox_s  = {TW{1'b0}};
        end else begin
          timer_prox_s = timer_r + 1'b1;
        end
      end
      OBSERVA: begin
        if (leds != 4'd0) begin
          silencio_prox_s = {SW{1'b0}};
        end else if (silencio_r != SIL_MAX) begin
          silencio_prox_s = silencio_r + 1'b1;
        end else begin
          silencio_prox_s = silencio_r;
        end
        // Malformed or overflowing items are flagged, never stored.
        if (captura_s && !um_quente(leds)) begin
          invalido_prox_s = 1'b1;
        end else if (captura_s && (n_obs_r >= OBS_MAX)) begin
          invalido_prox_s = 1'b1;
        end else if (captura_s) begin
          grava_s      = 1'b1;
          n_obs_prox_s = n_obs_r + 5'd1;
        end else begin
          invalido_prox_s = invalido_r;
        end
        if ((silencio_r == SIL_MAX) && (n_obs_r != 5'd0)) begin
          estado_caso_s = APERTA;
          idx_prox_s    = 5'd0;
          timer_prox_s  = {TW{1'b0}};
        end else begin
          estado_caso_s = OBSERVA;
        end
      end
      APERTA: begin
        if (timer_r == FIM_APERTO) begin
          estado_caso_s = SOLTA;
          timer_prox_s  = {TW{1'b0}};
        end else begin
          timer_prox_s = timer_r + 1'b1;
        end
      end
      SOLTA: begin
        if (timer_r != FIM_SOLTO) begin
          timer_prox_s = timer_r + 1'b1;
        end else if (idx_r < (n_obs_r - 5'd1)) begin
          estado_caso_s = APERTA;
          timer_prox_s  = {TW{1'b0}};
          idx_prox_s    = idx_r + 5'd1;
        end else begin
          estado_caso_s   = OBSERVA;
          timer_prox_s    = {TW{1'b0}};
          idx_prox_s      = 5'd0;
          n_obs_prox_s    = 5'd0;
          silencio_prox_s = {SW{1'b0}};
          rodada_prox_s   = rodada_r + 4'd1;
        end
      end
      default: begin
        estado_caso_s = OCIOSO;
      end
    endcase

    // End of game wins over any transition chosen above.
    if (pronto && (estado_r != OCIOSO) && (estado_r != FIM)) begin
      estado_prox_s    = FIM;
      resultado_prox_s = {perdeu, ganhou};
    end else begin
      estado_prox_s    = estado_caso_s;
      resultado_prox_s = resultado_caso_s;
    end
  end

  // Button value for the press about to be driven, with optional corruption.
  always_comb begin
    ultimo_s = (idx_prox_s == (n_obs_prox_s - 5'd1));
    if (erro_habilita && (rodada_prox_s == erro_rodada) && ultimo_s) begin
      botao_s = gira_esq(mem_dado_s);
    end else begin
      botao_s = mem_dado_s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r    <= OCIOSO;
      timer_r     <= {TW{1'b0}};
      silencio_r  <= {SW{1'b0}};
      n_obs_r     <= 5'd0;
      idx_r       <= 5'd0;
      rodada_r    <= 4'd0;
      resultado_r <= RES_NENHUM;
      invalido_r  <= 1'b0;
      leds_ant_r  <= 4'd0;
      jogar_r     <= 1'b0;
      botoes_r    <= 4'd0;
      ocupado_r   <= 1'b0;
      fim_r       <= 1'b0;
    end else begin
      estado_r    <= estado_prox_s;
      timer_r     <= timer_prox_s;
      silencio_r  <= silencio_prox_s;
      n_obs_r     <= n_obs_prox_s;
      idx_r       <= idx_prox_s;
      rodada_r    <= rodada_prox_s;
      resultado_r <= resultado_prox_s;
      invalido_r  <= invalido_prox_s;
      leds_ant_r  <= leds;
      jogar_r     <= (estado_prox_s == PULSO_JOGAR);
      botoes_r    <= (estado_prox_s == APERTA) ? botao_s : 4'd0;
      ocupado_r   <= (estado_prox_s != OCIOSO) && (estado_prox_s != FIM);
      fim_r       <= (estado_prox_s == FIM);
    end
  end

  assign jogar       = jogar_r;
  assign botoes      = botoes_r;
  assign ocupado     = ocupado_r;
  assign fim         = fim_r;
  assign resultado   = resultado_r;
  assign db_invalido = invalido_r;
  assign db_rodada   = rodada_r;
  assign db_estado   = estado_r;

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench: random LED rounds feed a sequence model that queues the
// expected presses; a negedge monitor pops and checks each press it sees.
module tb_jogador_automatico;

  localparam int T_AP = 5;
  localparam int T_SO = 5;
  localparam int T_JO = 5;
  localparam int T_SI = 20;
  localparam int NMAX = 16;

  logic       clock = 1'b0;
  logic       reset, iniciar, pronto, ganhou, perdeu, erro_habilita;
  logic [3:0] leds, erro_rodada;
  logic       jogar, ocupado, fim, db_invalido;
  logic [3:0] botoes, db_rodada, db_estado;
  logic [1:0] resultado;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] itens_q[$];
  bit         mon_en = 1'b0;
  int         model_rodada = 0;
  bit         model_inv = 1'b0;

  always #5 clock = ~clock;

  jogador_automatico #(
    .T_APERTO(T_AP), .T_SOLTO(T_SO), .T_JOGAR(T_JO), .T_SILENCIO(T_SI), .N_MAX(NMAX)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .leds(leds), .pronto(pronto),
    .ganhou(ganhou), .perdeu(perdeu), .erro_habilita(erro_habilita),
    .erro_rodada(erro_rodada), .jogar(jogar), .botoes(botoes), .ocupado(ocupado),
    .fim(fim), .resultado(resultado), .db_invalido(db_invalido),
    .db_rodada(db_rodada), .db_estado(db_estado)
  );

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nome, got, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Sequence model: store the first NMAX one-hot items, corrupt the chosen round's last press.
  task automatic model_push();
    logic [3:0] guardados[$];
    logic [3:0] v;
    int         n_hot;
    n_hot = 0;
    foreach (itens_q[i]) begin
      if ($countones(itens_q[i]) != 1) begin
        model_inv = 1'b1;
      end else begin
        n_hot++;
        if (guardados.size() < NMAX) guardados.push_back(itens_q[i]);
      end
    end
    if (n_hot > NMAX) model_inv = 1'b1;
    if (erro_habilita && (erro_rodada == model_rodada[3:0]) && (guardados.size() > 0)) begin
      v = guardados[guardados.size() - 1];
      guardados[guardados.size() - 1] = (v == 4'd8) ? 4'd1 : 4'(v * 2);
    end
    foreach (guardados[i]) exp_q.push_back(guardados[i]);
  endtask

  task automatic drive_items();
    int h, g;
    foreach (itens_q[i]) begin
      h = $urandom_range(4, 1);
      g = $urandom_range(6, 1);
      leds = itens_q[i];
      repeat (h) step();
      leds = 4'd0;
      repeat (g) step();
    end
  endtask

  task automatic fill_items(input int n, input bit com_invalido);
    logic [3:0] v;
    itens_q.delete();
    if (com_invalido) itens_q.push_back(4'b0011);
    for (int i = 0; i < n; i++) begin
      v = 4'b0001;
      v = v << $urandom_range(3, 0);
      itens_q.push_back(v);
    end
  endtask

  task automatic play_round(input int n, input bit com_invalido);
    fill_items(n, com_invalido);
    model_push();
    drive_items();
    model_rodada++;
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      if (db_rodada == model_rodada[3:0]) break;
    end
    check("rodada_fim", 32'(db_rodada), 32'(model_rodada[3:0]));
    check("estado_pos_rodada", 32'(db_estado), 32'd2);
    check("invalido", 32'(db_invalido), 32'(model_inv));
    check("fila_vazia", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic start_game();
    int cnt;
    cnt = 0;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    model_rodada = 0;
    model_inv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (jogar) cnt++;
      else break;
    end
    check("jogar_largura", 32'(cnt), 32'(T_JO));
    check("estado_observa", 32'(db_estado), 32'd2);
    check("ocupado_jogo", 32'(ocupado), 32'd1);
    check("fim_jogo", 32'(fim), 32'd0);
    check("resultado_limpo", 32'(resultado), 32'd0);
    check("invalido_limpo", 32'(db_invalido), 32'd0);
    check("rodada_limpa", 32'(db_rodada), 32'd0);
  endtask

  task automatic wait_press(input logic [3:0] alvo);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if ((botoes != 4'd0) && ((alvo == 4'd0) || (botoes == alvo))) break;
    end
  endtask

  // Monitor: pops one expectation per completed press and checks timing.
  logic [3:0] run_b;
  int         run_len, sol_len;
  logic [3:0] esperado;
  always @(negedge clock) begin
    if (!mon_en) begin
      run_b = 4'd0;
      run_len = 0;
      sol_len = 0;
    end else begin
      check("botoes_so_aperta", 32'((botoes != 4'd0) && (db_estado != 4'd3)), 32'd0);
      check("jogar_so_pulso", 32'(jogar && (db_estado != 4'd1)), 32'd0);
      if (botoes != run_b) begin
        if (run_b != 4'd0) begin
          if (exp_q.size() == 0) begin
            check("press_inesperado", 32'(run_b), 32'd0);
          end else begin
            esperado = exp_q.pop_front();
            check("press_valor", 32'(run_b), 32'(esperado));
            check("press_largura", 32'(run_len), 32'(T_AP));
          end
        end
        run_b = botoes;
        run_len = 1;
      end else begin
        run_len++;
      end
      if (db_estado == 4'd4) begin
        sol_len++;
      end else if (sol_len != 0) begin
        check("solta_largura", 32'(sol_len), 32'(T_SO));
        sol_len = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; iniciar = 1'b0; pronto = 1'b0; ganhou = 1'b0; perdeu = 1'b0;
    erro_habilita = 1'b0; erro_rodada = 4'd0; leds = 4'd0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    check("rst_estado", 32'(db_estado), 32'd0);
    check("rst_jogar", 32'(jogar), 32'd0);
    check("rst_botoes", 32'(botoes), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_fim", 32'(fim), 32'd0);
    check("rst_resultado", 32'(resultado), 32'd0);
    check("rst_invalido", 32'(db_invalido), 32'd0);
    check("rst_rodada", 32'(db_rodada), 32'd0);

    // Game 1: growing rounds, round 3 has its last press corrupted, then a loss.
    mon_en = 1'b1;
    erro_habilita = 1'b1;
    erro_rodada = 4'd3;
    start_game();
    for (int r = 0; r < 5; r++) play_round(r + 1, 1'b0);
    pronto = 1'b1; perdeu = 1'b1;
    step();
    pronto = 1'b0; perdeu = 1'b0;
    @(negedge clock);
    check("perdeu_resultado", 32'(resultado), 32'd2);
    check("perdeu_fim", 32'(fim), 32'd1);
    check("perdeu_estado", 32'(db_estado), 32'd15);
    check("perdeu_ocupado", 32'(ocupado), 32'd0);
    repeat (3) step();
    @(negedge clock);
    check("fim_mantem_resultado", 32'(resultado), 32'd2);

    // Game 2: malformed item plus overflow, then a random corrupted round, then a win mid-press.
    erro_habilita = 1'b0;
    start_game();
    play_round(17, 1'b1);
    erro_habilita = 1'b1;
    erro_rodada = 4'd1;
    play_round($urandom_range(5, 2), 1'b0);
    mon_en = 1'b0;
    fill_items(2, 1'b0);
    drive_items();
    wait_press(4'd0);
    check("aperta_antes_pronto", 32'(db_estado), 32'd3);
    pronto = 1'b1; ganhou = 1'b1;
    step();
    pronto = 1'b0; ganhou = 1'b0;
    @(negedge clock);
    check("ganhou_botoes", 32'(botoes), 32'd0);
    check("ganhou_resultado", 32'(resultado), 32'd1);
    check("ganhou_fim", 32'(fim), 32'd1);
    check("ganhou_jogar", 32'(jogar), 32'd0);

    // Game 3: one normal round, then reset (with iniciar and pronto) in the middle of a press.
    mon_en = 1'b1;
    erro_habilita = 1'b0;
    start_game();
    play_round(1, 1'b0);
    mon_en = 1'b0;
    itens_q.delete();
    itens_q.push_back(4'b0100);
    drive_items();
    wait_press(4'b0100);
    check("aperta_0100", 32'(botoes), 32'h4);
    reset = 1'b1; iniciar = 1'b1; pronto = 1'b1;
    step();
    reset = 1'b0; iniciar = 1'b0; pronto = 1'b0;
    @(negedge clock);
    check("rst_meio_botoes", 32'(botoes), 32'd0);
    check("rst_meio_estado", 32'(db_estado), 32'd0);
    check("rst_meio_rodada", 32'(db_rodada), 32'd0);
    check("rst_meio_ocupado", 32'(ocupado), 32'd0);
    check("rst_meio_jogar", 32'(jogar), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
